// File: rtl/fetch_if.sv
// Interface bundling the fetch stage's control inputs, instruction-memory port
// and IF/ID pipeline-register outputs.
// master: the fetch stage itself. slave: the surrounding pipeline and memory.
interface fetch_if;
  // Hazard and redirect controls coming from later stages
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;

  // Instruction memory port
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;

  // IF/ID pipeline register and halt status
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_inc;
  logic        ifid_valid;
  logic        hlt;

  modport master (
    input  stall, br_taken, br_target, im_instr,
    output im_addr, im_rd_en, ifid_instr, ifid_pc_inc, ifid_valid, hlt
  );

  modport slave (
    output stall, br_taken, br_target, im_instr,
    input  im_addr, im_rd_en, ifid_instr, ifid_pc_inc, ifid_valid, hlt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 16-bit WISC pipeline.
//
// The PC register drives the word-addressed instruction memory directly, so
// the memory sees a stable address for its clock-low read. The returned word
// is captured into IF/ID on the next posedge (fetch latency 1).
//
// Per-edge priority: rst > br_taken > stall > normal fetch.
// Fetching an HLT freezes the PC and stops memory reads. Bubbles are then
// injected for DRAIN_CYCLES cycles so the older instructions can retire, and
// the stage then halts. Only reset leaves the halted state. A branch taken
// during the drain means the HLT was in a branch shadow, so fetch resumes.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE   = 4'hF,
  // Must be at least 1.
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t           state_q,       state_d;
  logic [15:0]      pc_q,          pc_d;
  logic [CNT_W-1:0] drain_cnt_q,   drain_cnt_d;
  logic [15:0]      ifid_instr_q,  ifid_instr_d;
  logic [15:0]      ifid_pc_inc_q, ifid_pc_inc_d;
  logic             ifid_valid_q,  ifid_valid_d;
  logic             hlt_q,         hlt_d;

  logic [15:0]      pc_inc;
  logic             is_hlt;

  assign pc_inc = pc_q + 16'd1;  // wraps FFFF -> 0000 by design
  assign is_hlt = (bus.im_instr[15:12] == HLT_OPCODE);

  // Next-state logic for the PC, IF/ID register, drain counter and FSM
  always_comb begin
    // NOTE: every signal written here gets a default first, so a path that
    // does not assign it holds the flop value instead of inferring a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    drain_cnt_d   = drain_cnt_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_inc_d = ifid_pc_inc_q;
    ifid_valid_d  = ifid_valid_q;
    hlt_d         = hlt_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.br_taken) begin
          // Redirect wins over stall: squash the wrong-path word.
          pc_d          = bus.br_target;
          ifid_instr_d  = NOP_INSTR;
          ifid_pc_inc_d = 16'h0000;
          ifid_valid_d  = 1'b0;
        end else if (!bus.stall) begin
          ifid_instr_d  = bus.im_instr;
          ifid_pc_inc_d = pc_inc;
          ifid_valid_d  = 1'b1;
          if (is_hlt) begin
            // The HLT itself goes down the pipe. The PC stays on its address.
            state_d     = ST_HALT_PEND;
            drain_cnt_d = '0;
          end else begin
            pc_d        = pc_inc;
          end
        end
      end

      ST_HALT_PEND: begin
        if (bus.br_taken) begin
          // The HLT was fetched in a branch shadow, so fetch resumes at the target.
          state_d       = ST_RUN;
          drain_cnt_d   = '0;
          pc_d          = bus.br_target;
          ifid_instr_d  = NOP_INSTR;
          ifid_pc_inc_d = 16'h0000;
          ifid_valid_d  = 1'b0;
        end else if (!bus.stall) begin
          ifid_instr_d  = NOP_INSTR;
          ifid_pc_inc_d = 16'h0000;
          ifid_valid_d  = 1'b0;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = ST_HALTED;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end

      ST_HALTED: begin
        // Everything is frozen. br_taken and stall have no effect here.
        hlt_d = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register. The reset is asynchronous, so it takes effect between edges too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      drain_cnt_q   <= '0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_inc_q <= 16'h0000;
      ifid_valid_q  <= 1'b0;
      hlt_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from
      // values sampled at the edge, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_cnt_q   <= drain_cnt_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_inc_q <= ifid_pc_inc_d;
      ifid_valid_q  <= ifid_valid_d;
      hlt_q         <= hlt_d;
    end
  end

  // The memory address comes straight from the PC flop, with no path from the inputs.
  // The read enable drops while reset is held.
  assign bus.im_addr     = pc_q;
  assign bus.im_rd_en    = (state_q == ST_RUN) && !rst;
  assign bus.ifid_instr  = ifid_instr_q;
  assign bus.ifid_pc_inc = ifid_pc_inc_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.hlt         = hlt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: straight-line fetch, stall, redirect,
// HLT drain (with and without stalls), HLT in a branch shadow, PC wrap and
// asynchronous reset.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus_if ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Instruction memory model: 256 words, and the address is taken modulo 256.
  logic [15:0] mem [256];
  always_comb bus_if.im_instr = mem[bus_if.im_addr[7:0]];

  int tests = 0;
  int fails = 0;

  // Observed output vector: addr[50:35] rd[34] instr[33:18] inc[17:2] valid[1] hlt[0]
  typedef logic [50:0] vec_t;
  vec_t obs;
  assign obs = {bus_if.im_addr, bus_if.im_rd_en, bus_if.ifid_instr,
                bus_if.ifid_pc_inc, bus_if.ifid_valid, bus_if.hlt};

  // ALL compares every field. NOINC skips ifid_pc_inc, which has no defined value on a bubble.
  localparam vec_t ALL   = '1;
  localparam vec_t NOINC = {16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1};

  function automatic vec_t ev(input logic [15:0] a, input logic rd, input logic [15:0] ins,
                              input logic [15:0] inc, input logic v, input logic h);
    return {a, rd, ins, inc, v, h};
  endfunction

  function automatic string fmt(input vec_t x);
    return $sformatf("addr=%h rd=%b instr=%h inc=%h valid=%b hlt=%b",
                     x[50:35], x[34], x[33:18], x[17:2], x[1], x[0]);
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.br_taken = 1'b0;
    bus_if.br_target = 16'h0000;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    logic [15:0] exp_instr [4];
    exp_instr[0] = 16'h1234; exp_instr[1] = 16'h5678;
    exp_instr[2] = 16'h9ABC; exp_instr[3] = 16'h0000;
    rst = 1'b1;
    bus_if.stall = 1'b0; bus_if.br_taken = 1'b0; bus_if.br_target = 16'h0000;
    step();
    e = ev(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_hold: got %s want %s", fmt(obs), fmt(e)); end
    rst = 1'b0;
    #1;
    e = ev(16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_release: got %s want %s", fmt(obs), fmt(e)); end
    for (int i = 0; i < 4; i++) begin
      step();
      e = ev(16'(i + 1), 1'b1, exp_instr[i], 16'(i + 1), 1'b1, 1'b0);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL straight_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_stall();
    vec_t e;
    do_reset();
    step();
    step();
    bus_if.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = ev(16'h0002, 1'b1, 16'h5678, 16'h0002, 1'b1, 1'b0);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL stall_hold_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
    end
    bus_if.stall = 1'b0;
    step();
    e = ev(16'h0003, 1'b1, 16'h9ABC, 16'h0003, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL stall_resume: got %s want %s", fmt(obs), fmt(e)); end
  endtask

  // Continues from pc=3, where test_stall leaves the stage.
  task automatic test_redirect();
    vec_t e;
    bus_if.br_taken = 1'b1; bus_if.br_target = 16'h0040; bus_if.stall = 1'b1;
    step();
    e = ev(16'h0040, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL redirect_flush: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.br_taken = 1'b0; bus_if.stall = 1'b0;
    step();
    e = ev(16'h0041, 1'b1, 16'hAAAA, 16'h0041, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL redirect_target: got %s want %s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_hlt_drain();
    vec_t e;
    do_reset();
    repeat (5) step();
    e = ev(16'h0005, 1'b1, 16'h4444, 16'h0005, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL pre_hlt: got %s want %s", fmt(obs), fmt(e)); end
    step();
    e = ev(16'h0005, 1'b0, 16'hF000, 16'h0006, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL hlt_capture: got %s want %s", fmt(obs), fmt(e)); end
    for (int i = 1; i <= 4; i++) begin
      step();
      e = ev(16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tests++;
      if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL drain_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
    end
    step();
    e = ev(16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL hlt_assert: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.br_taken = 1'b1; bus_if.br_target = 16'h0010; bus_if.stall = 1'b1;
    step();
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL halted_br: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.br_taken = 1'b0; bus_if.stall = 1'b0;
    step();
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL halted_sticky: got %s want %s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_hlt_stall();
    vec_t e;
    do_reset();
    repeat (5) step();
    bus_if.stall = 1'b1;
    step();
    e = ev(16'h0005, 1'b1, 16'h4444, 16'h0005, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL hlt_stalled: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.stall = 1'b0;
    step();
    e = ev(16'h0005, 1'b0, 16'hF000, 16'h0006, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL hlt_refetch: got %s want %s", fmt(obs), fmt(e)); end
    step();
    bus_if.stall = 1'b1;
    step();
    step();
    bus_if.stall = 1'b0;
    step();
    step();
    e = ev(16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL drain_stall_hold: got %s want %s", fmt(obs), fmt(e)); end
    step();
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL drain_stall_late: got %s want %s", fmt(obs), fmt(e)); end
    step();
    e = ev(16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL drain_stall_hlt: got %s want %s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_hlt_shadow();
    vec_t e;
    do_reset();
    repeat (6) step();
    step();
    bus_if.br_taken = 1'b1; bus_if.br_target = 16'h0010;
    step();
    e = ev(16'h0010, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL shadow_redirect: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.br_taken = 1'b0;
    step();
    e = ev(16'h0011, 1'b1, 16'h1010, 16'h0011, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL shadow_fetch: got %s want %s", fmt(obs), fmt(e)); end
    for (int i = 0; i < 6; i++) begin
      step();
      e = ev(16'(16'h0012 + i), 1'b1, 16'h0000, 16'(16'h0012 + i), 1'b1, 1'b0);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL shadow_run_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_wrap_async();
    vec_t e;
    do_reset();
    bus_if.br_taken = 1'b1; bus_if.br_target = 16'hFFFF;
    step();
    e = ev(16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if ((obs & NOINC) !== (e & NOINC)) begin fails++; $display("FAIL wrap_setup: got %s want %s", fmt(obs), fmt(e)); end
    bus_if.br_taken = 1'b0;
    step();
    e = ev(16'h0000, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL wrap: got %s want %s", fmt(obs), fmt(e)); end

    // Reset raised between edges while the drain is in progress
    do_reset();
    repeat (6) step();
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    e = ev(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL async_rst_drain: got %s want %s", fmt(obs), fmt(e)); end
    step();
    rst = 1'b0;
    #1;
    e = ev(16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL async_rst_release: got %s want %s", fmt(obs), fmt(e)); end
    step();
    e = ev(16'h0001, 1'b1, 16'h1234, 16'h0001, 1'b1, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL async_rst_refetch: got %s want %s", fmt(obs), fmt(e)); end

    // Reset raised between edges after the stage has halted
    do_reset();
    repeat (6) step();
    repeat (5) step();
    #3;
    rst = 1'b1;
    #1;
    e = ev(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tests++;
    if (obs !== e) begin fails++; $display("FAIL async_rst_halted: got %s want %s", fmt(obs), fmt(e)); end
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h1234;
    mem[1]    = 16'h5678;
    mem[2]    = 16'h9ABC;
    mem[3]    = 16'h0000;
    mem[4]    = 16'h4444;
    mem[5]    = 16'hF000;
    mem[8'h10] = 16'h1010;
    mem[8'h40] = 16'hAAAA;
    mem[8'hFF] = 16'hBEEF;

    test_reset();
    test_stall();
    test_redirect();
    test_hlt_drain();
    test_hlt_stall();
    test_hlt_shadow();
    test_wrap_async();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
